// File: rtl/occupancy_grid_updater.sv
// Read-modify-write controller for the 256x128x8 occupancy grid RAM.
// Applies saturating log-odds hit/miss updates to single cells and provides
// a whole-grid clear that writes CLEAR_VALUE to every cell.
module occupancy_grid_updater #(
   parameter int unsigned HIT_INCREMENT  = 8,
   parameter int unsigned MISS_DECREMENT = 2,
   parameter int unsigned CELL_MAX       = 255,
   parameter int unsigned CELL_MIN       = 0,
   parameter int unsigned CLEAR_VALUE    = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_x,
   input  logic [6:0]  in_y,
   input  logic        in_hit,
   input  logic        clear_start,
   output logic        busy,
   output logic        update_done,
   output logic        clear_done,
   output logic        ram_write_enable,
   output logic [14:0] ram_address,
   output logic [7:0]  ram_input_data,
   input  logic [7:0]  ram_output_data
);

   // 10-bit signed versions of the parameters so over/underflow is visible.
   localparam logic signed [9:0] HitInc   = 10'(HIT_INCREMENT);
   localparam logic signed [9:0] MissDec  = 10'(MISS_DECREMENT);
   localparam logic signed [9:0] CellMax  = 10'(CELL_MAX);
   localparam logic signed [9:0] CellMin  = 10'(CELL_MIN);
   localparam logic [7:0]        ClearVal = 8'(CLEAR_VALUE);
   localparam logic [14:0]       LastAddr = '1;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StModify,
      StWrite,
      StClear
   } state_e;

   state_e      state_q, state_d;
   logic        hit_q, hit_d;
   logic [14:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        upd_done_q, upd_done_d;
   logic        clr_done_q, clr_done_d;

   logic signed [9:0] old_ext;
   logic signed [9:0] sum_ext;
   logic signed [9:0] diff_ext;
   logic signed [9:0] new_ext;
   logic [7:0]        new_value;

   // Saturating log-odds update of the cell value returned by the RAM.
   always_comb begin
      old_ext  = {2'b00, ram_output_data};
      sum_ext  = old_ext + HitInc;
      diff_ext = old_ext - MissDec;
      new_ext  = old_ext;
      if (hit_q) begin
         new_ext = (sum_ext > CellMax) ? CellMax : sum_ext;
      end else begin
         new_ext = (diff_ext < CellMin) ? CellMin : diff_ext;
      end
      new_value = new_ext[7:0];
   end

   // Next-state and registered-output decode; every output is computed one
   // cycle ahead so the ports come straight from flops.
   always_comb begin
      state_d    = state_q;
      hit_d      = hit_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      ready_d    = 1'b0;
      busy_d     = 1'b1;
      upd_done_d = 1'b0;
      clr_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            // A clear request beats a simultaneous observation.
            if (clear_start) begin
               state_d = StClear;
               addr_d  = '0;
               wdata_d = ClearVal;
               we_d    = 1'b1;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end else if (in_valid && ready_q) begin
               state_d = StRead;
               hit_d   = in_hit;
               addr_d  = {in_y, in_x};
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end

         StRead: begin
            // RAM captures memory[addr] at the end of this cycle.
            state_d = StModify;
         end

         StModify: begin
            state_d    = StWrite;
            wdata_d    = new_value;
            we_d       = 1'b1;
            upd_done_d = 1'b1;
         end

         StWrite: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end

         StClear: begin
            wdata_d = ClearVal;
            if (addr_q == LastAddr) begin
               state_d = StIdle;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               addr_d     = addr_q + 15'd1;
               we_d       = 1'b1;
               // Pulse lines up with the cycle that writes the last cell.
               clr_done_d = (addr_q == LastAddr - 15'd1);
            end
         end

         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any pending write.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         hit_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         upd_done_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hit_q      <= hit_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         upd_done_q <= upd_done_d;
         clr_done_q <= clr_done_d;
      end
   end

   assign in_ready         = ready_q;
   assign busy             = busy_q;
   assign update_done      = upd_done_q;
   assign clear_done       = clr_done_q;
   assign ram_write_enable = we_q;
   assign ram_address      = addr_q;
   assign ram_input_data   = wdata_q;

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// Bench for occupancy_grid_updater: RAM model plus a cell-array reference
// model updated with plain saturating integer arithmetic.
module tb_occupancy_grid_updater;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x;
   logic [6:0]  in_y;
   logic        in_hit;
   logic        clear_start;
   logic        busy;
   logic        update_done;
   logic        clear_done;
   logic        ram_write_enable;
   logic [14:0] ram_address;
   logic [7:0]  ram_input_data;
   logic [7:0]  ram_output_data;

   logic [7:0] mem [0:32767];
   int         exp_mem [0:32767];
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;

   always #5 clock = ~clock;

   occupancy_grid_updater dut (
      .clock            (clock),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_x             (in_x),
      .in_y             (in_y),
      .in_hit           (in_hit),
      .clear_start      (clear_start),
      .busy             (busy),
      .update_done      (update_done),
      .clear_done       (clear_done),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_input_data   (ram_input_data),
      .ram_output_data  (ram_output_data)
   );

   // Grid RAM: registered read, read-before-write.
   always @(posedge clock) begin
      if (ram_write_enable === 1'b1) mem[ram_address] <= ram_input_data;
      ram_output_data <= mem[ram_address];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got busy=%b need finish", busy);
      $fatal(1, "watchdog");
   end

   function automatic int apply_obs(input int old, input bit hit);
      int v;
      if (hit) v = (old + 8 > 255) ? 255 : old + 8;
      else     v = (old - 2 < 0) ? 0 : old - 2;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40 && !(busy === 1'b0 && in_ready === 1'b1); n++) step();
      vectors++;
      if (!(busy === 1'b0 && in_ready === 1'b1)) begin
         miscompares++;
         $display("FAIL wait_idle: busy=%b in_ready=%b, need 0/1", busy, in_ready);
      end
   endtask

   task automatic compare_memory(input string name);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 32768; i++) begin
         if (int'(mem[i]) !== exp_mem[i]) begin
            if (first < 0) first = i;
            bad++;
         end
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL %s: %0d cells differ, first at %0d got %0d need %0d",
                  name, bad, first, mem[first], exp_mem[first]);
      end
   endtask

   // One observation through the full accept/read/modify/write sequence.
   task automatic do_update(input logic [7:0] x, input logic [6:0] y, input logic hit);
      logic [14:0] a;
      int          expv;
      int          pulses;
      a = {y, x};
      expv = apply_obs(exp_mem[a], hit);
      in_x = x; in_y = y; in_hit = hit; in_valid = 1'b1;
      for (int n = 0; n < 20 && in_ready !== 1'b1; n++) step();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL upd_ready: in_ready=%b need 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      step();
      in_valid = 1'b0;
      pulses = 0;
      vectors++;
      if (!(ram_address === a && busy === 1'b1 && in_ready === 1'b0 && ram_write_enable === 1'b0)) begin
         miscompares++;
         $display("FAIL upd_read: addr=%h busy=%b rdy=%b we=%b need %h/1/0/0",
                  ram_address, busy, in_ready, ram_write_enable, a);
      end
      if (update_done === 1'b1) pulses++;
      step();
      vectors++;
      if (ram_write_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL upd_modify_we: we=%b need 0", ram_write_enable);
      end
      if (update_done === 1'b1) pulses++;
      step();
      vectors++;
      if (!(ram_write_enable === 1'b1 && ram_address === a && int'(ram_input_data) === expv)) begin
         miscompares++;
         $display("FAIL upd_write: we=%b addr=%h data=%0d need 1/%h/%0d",
                  ram_write_enable, ram_address, ram_input_data, a, expv);
      end
      if (update_done === 1'b1) pulses++;
      exp_mem[a] = expv;
      step();
      vectors++;
      if (ram_write_enable !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL upd_after: we=%b busy=%b need 0/0", ram_write_enable, busy);
      end
      if (update_done === 1'b1) pulses++;
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL upd_done_pulses: got %0d need 1", pulses);
      end
   endtask

   // Full clear, optionally with a competing observation presented at the start.
   task automatic run_clear(input logic with_valid, input logic [7:0] x, input logic [6:0] y);
      int bad = 0;
      int first = -1;
      wait_idle();
      clear_start = 1'b1;
      in_valid = with_valid; in_x = x; in_y = y; in_hit = 1'b1;
      step();
      clear_start = 1'b0;
      for (int i = 0; i < 32768; i++) begin
         if (!(ram_write_enable === 1'b1 && ram_address === 15'(i) && ram_input_data === 8'd128 &&
               busy === 1'b1 && in_ready === 1'b0 && update_done === 1'b0 &&
               clear_done === (i == 32767))) begin
            if (first < 0) first = i;
            bad++;
         end
         step();
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL clear_seq: %0d bad cycles, first at index %0d", bad, first);
      end
      vectors++;
      if (!(busy === 1'b0 && in_ready === 1'b1 && ram_write_enable === 1'b0 && clear_done === 1'b0)) begin
         miscompares++;
         $display("FAIL clear_end: busy=%b rdy=%b we=%b cd=%b need 0/1/0/0",
                  busy, in_ready, ram_write_enable, clear_done);
      end
      for (int i = 0; i < 32768; i++) exp_mem[i] = 128;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_hit = 1'b0; clear_start = 1'b0;
      step(); step();
      vectors++;
      if ({in_ready, busy, update_done, clear_done, ram_write_enable} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b need 00000",
                  {in_ready, busy, update_done, clear_done, ram_write_enable});
      end
      vectors++;
      if (ram_address !== 15'd0 || ram_input_data !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_bus: addr=%h data=%h need 0/0", ram_address, ram_input_data);
      end
      reset = 1'b0;
      step();
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: rdy=%b busy=%b need 1/0", in_ready, busy);
      end
   endtask

   task automatic test_clear();
      run_clear(1'b0, 8'd0, 7'd0);
      compare_memory("clear_contents");
   endtask

   task automatic test_hit_basic();
      do_update(8'd10, 7'd5, 1'b1);
      vectors++;
      if (mem[15'h050A] !== 8'd136) begin
         miscompares++;
         $display("FAIL hit_basic: cell 050A got %0d need 136", mem[15'h050A]);
      end
   endtask

   task automatic test_back_to_back();
      int t0, t1;
      int e1, e2;
      logic [7:0] wr [$];
      e1 = apply_obs(exp_mem[15'h050A], 1'b0);
      e2 = apply_obs(e1, 1'b1);
      wait_idle();
      in_x = 8'd10; in_y = 7'd5; in_hit = 1'b0; in_valid = 1'b1;
      t0 = cyc;
      step();
      in_hit = 1'b1;
      for (int n = 0; n < 20 && in_ready !== 1'b1; n++) begin
         if (ram_write_enable === 1'b1) wr.push_back(ram_input_data);
         step();
      end
      t1 = cyc;
      step();
      in_valid = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (ram_write_enable === 1'b1) wr.push_back(ram_input_data);
         step();
      end
      vectors++;
      if (t1 - t0 != 4) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d cycles need 4", t1 - t0);
      end
      vectors++;
      if (wr.size() != 2 || int'(wr[0]) !== e1 || int'(wr[1]) !== e2 || wr[0] !== 8'd134) begin
         miscompares++;
         $display("FAIL b2b_writes: got %0d writes first=%0d need 2 writes %0d,%0d",
                  wr.size(), (wr.size() > 0) ? int'(wr[0]) : -1, e1, e2);
      end
      exp_mem[15'h050A] = e2;
      vectors++;
      if (mem[15'h050A] !== 8'd142) begin
         miscompares++;
         $display("FAIL b2b_cell: got %0d need 142", mem[15'h050A]);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 16; i++) do_update(8'd255, 7'd127, 1'b1);
      vectors++;
      if (mem[15'h7FFF] !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_max: cell 7FFF got %0d need 255", mem[15'h7FFF]);
      end
      for (int i = 0; i < 65; i++) do_update(8'd0, 7'd0, 1'b0);
      vectors++;
      if (mem[0] !== 8'd0) begin
         miscompares++;
         $display("FAIL sat_min: cell 0 got %0d need 0", mem[0]);
      end
   endtask

   task automatic test_clear_priority();
      int expv;
      run_clear(1'b1, 8'd3, 7'd2);
      expv = apply_obs(exp_mem[15'h0203], 1'b1);
      step();
      in_valid = 1'b0;
      vectors++;
      if (ram_address !== 15'h0203 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL prio_accept: addr=%h busy=%b need 0203/1", ram_address, busy);
      end
      step(); step();
      vectors++;
      if (ram_write_enable !== 1'b1 || int'(ram_input_data) !== expv) begin
         miscompares++;
         $display("FAIL prio_write: we=%b data=%0d need 1/%0d", ram_write_enable, ram_input_data, expv);
      end
      exp_mem[15'h0203] = expv;
      step();
      vectors++;
      if (mem[15'h0203] !== 8'd136) begin
         miscompares++;
         $display("FAIL prio_cell: got %0d need 136", mem[15'h0203]);
      end
   endtask

   task automatic test_random();
      int bias;
      for (int i = 0; i < 150; i++) begin
         if (i % 50 == 0) bias = $urandom_range(1, 3);
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
         if (i % 8 == 7)
            do_update(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
         else
            do_update(8'($urandom_range(0, 3)), 7'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) < 32'(bias)) ? 1'b1 : 1'b0);
      end
      compare_memory("random_contents");
   endtask

   task automatic test_reset_modify();
      logic [14:0] a;
      a = {7'd7, 8'd20};
      wait_idle();
      in_x = 8'd20; in_y = 7'd7; in_hit = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      vectors++;
      if (ram_write_enable !== 1'b0 || busy !== 1'b0 || update_done !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mod_nowrite: we=%b busy=%b ud=%b need 0/0/0",
                  ram_write_enable, busy, update_done);
      end
      reset = 1'b0;
      step();
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || ram_write_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mod_idle: rdy=%b busy=%b we=%b need 1/0/0", in_ready, busy, ram_write_enable);
      end
      step();
      vectors++;
      if (int'(mem[a]) !== exp_mem[a]) begin
         miscompares++;
         $display("FAIL rst_mod_cell: got %0d need %0d", mem[a], exp_mem[a]);
      end
   endtask

   task automatic test_reset_clear();
      wait_idle();
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      for (int i = 0; i < 1000; i++) step();
      vectors++;
      if (ram_address !== 15'd1000 || ram_write_enable !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_clr_pos: addr=%0d we=%b need 1000/1", ram_address, ram_write_enable);
      end
      reset = 1'b1;
      step();
      vectors++;
      if (ram_write_enable !== 1'b0 || busy !== 1'b0 || clear_done !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_clr_nowrite: we=%b busy=%b cd=%b need 0/0/0",
                  ram_write_enable, busy, clear_done);
      end
      reset = 1'b0;
      step();
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_clr_idle: rdy=%b busy=%b need 1/0", in_ready, busy);
      end
      // The cycle at counter 1000 had its write issued before reset took effect.
      for (int i = 0; i <= 1000; i++) exp_mem[i] = 128;
      step(); step();
      vectors++;
      if (mem[0] !== 8'd128 || mem[999] !== 8'd128) begin
         miscompares++;
         $display("FAIL rst_clr_low: cell0=%0d cell999=%0d need 128/128", mem[0], mem[999]);
      end
      compare_memory("rst_clr_contents");
   endtask

   initial begin
      test_reset();
      test_clear();
      test_hit_basic();
      test_back_to_back();
      test_saturation();
      test_clear_priority();
      test_random();
      test_reset_modify();
      test_reset_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/occupancy_grid_updater.md
Name: occupancy_grid_updater

Overview:
- Read-modify-write controller directly upstream of the 256x128x8 occupancy grid RAM (15-bit address, 1-cycle registered read, read-before-write).
- Accepts per-cell hit/miss observations from the scan-insertion stage, applies a saturating log-odds update and writes the cell back.
- Also provides a whole-grid clear sequence used at map reset.

Parameters:
- HIT_INCREMENT, 8, unsigned amount added to a cell on a hit.
- MISS_DECREMENT, 2, unsigned amount subtracted from a cell on a miss.
- CELL_MAX, 255, upper saturation bound.
- CELL_MIN, 0, lower saturation bound.
- CLEAR_VALUE, 128, value written to every cell by a clear (unknown occupancy).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  observation present.
- in_ready  output  1  observation accepted this cycle when in_valid && in_ready.
- in_x  input  8  cell column, 0..255.
- in_y  input  7  cell row, 0..127.
- in_hit  input  1  1 = hit (increment), 0 = miss (decrement).
- clear_start  input  1  request full-grid clear.
- busy  output  1  high in any state other than IDLE.
- update_done  output  1  one-cycle pulse when an update's write is issued.
- clear_done  output  1  one-cycle pulse when the last clear write is issued.
- ram_write_enable  output  1  to RAM write_enable.
- ram_address  output  15  to RAM address, {y, x}.
- ram_input_data  output  8  to RAM input_data.
- ram_output_data  input  8  from RAM output_data.

Behaviour:
- Interface decided: one clock (clock), synchronous active-high reset (reset).
- All outputs registered. Reset values: in_ready 0 during the reset cycle, then 1 in IDLE; busy 0; update_done 0; clear_done 0; ram_write_enable 0; ram_address 0; ram_input_data 0.
- States: IDLE, READ, MODIFY, WRITE, CLEAR.
- IDLE:
  - in_ready = 1.
  - clear_start has priority. If clear_start is high, go to CLEAR, load address counter 0, in_ready drops, and in_valid is not accepted.
  - Else if in_valid is high, latch in_hit, register ram_address = {in_y, in_x}, and go to READ.
- READ:
  - Address is stable at the RAM.
  - At the end of this cycle the RAM registers memory[address].
  - Go to MODIFY.
- MODIFY:
  - ram_output_data is valid. Compute new value with a 10-bit signed intermediate.
  - Hit: min(old + HIT_INCREMENT, CELL_MAX).
  - Miss: max(old - MISS_DECREMENT, CELL_MIN).
  - Register ram_input_data = new value and ram_write_enable = 1. Go to WRITE.
- WRITE:
  - ram_write_enable is high for exactly this cycle and the RAM commits on this edge.
  - update_done pulses in this cycle.
  - Next state IDLE, with ram_write_enable returned to 0.
- Throughput: one update per 4 cycles (accept, READ, MODIFY, WRITE). The next accept can occur in the cycle after WRITE.
- Updates are fully serialised, so back-to-back updates to the same cell always read the previous write's result; no forwarding is needed.
- CLEAR:
  - ram_write_enable = 1 and ram_input_data = CLEAR_VALUE every cycle; ram_address = counter.
  - Counter increments by 1 per cycle from 0 to 32767.
  - clear_done pulses in the cycle address 32767 is written. Next state IDLE. Total 32768 write cycles.
- clear_start and in_valid are ignored outside IDLE; in_ready = 0 whenever busy.
- Reset mid-update or mid-clear: return to IDLE next cycle with ram_write_enable 0. Any write not yet issued is dropped. A partial clear is not resumed. RAM contents already written persist.
- Boundary values:
  - Cell at CELL_MAX + hit stays CELL_MAX.
  - Cell at CELL_MIN + miss stays CELL_MIN.
  - Corner addresses: (255,127) maps to 32767 and (0,0) maps to 0.

Test Plan:
- Reset, pulse clear_start: 32768 consecutive writes of 128 at addresses 0..32767, busy high throughout, clear_done on the final write, in_ready 0 during the clear; every cell then reads 128.
- After the clear, hit at (10,5): ram_address 0x050A, ram_write_enable high 3 cycles after accept, cell becomes 136, update_done pulses once.
- Miss at (10,5) then hit at (10,5) back-to-back with in_valid held high: second accept is 4 cycles after the first; cell goes 136, 134, 142.
- Saturation: 16 hits on (255,127) from 128 leave the cell at 255 (address 0x7FFF). 65 misses on (0,0) from 128 leave the cell at 0.
- clear_start and in_valid both high in IDLE: the clear wins and the observation is not accepted. The observation is accepted in the first IDLE cycle after clear_done, provided in_valid is still high.
- Assert reset in MODIFY, and separately at counter 1000 of a clear: no write occurs in the following cycle, busy is 0 and in_ready is 1 after reset. The cell being updated is unchanged, and cells 0..999 hold 128.
